// File: rtl/sub_dispatcher.sv
// -----------------------------------------------------------------------------
// sub_dispatcher
//   Hands fork requests from the main core to idle sub cores, chosen by
//   round-robin. For each sub core it issues a one-cycle launch pulse with the
//   start PC and tracks the core as busy until the core reports ended. A join
//   handshake completes once every sub core is idle.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   fork_valid/pc   launch request from main, held stable while valid
//   fork_ready      an idle core exists and no join is pending
//   fork_id         core picked for the current request
//   join_req        level request: wait until all sub cores are idle
//   join_done       one-cycle completion pulse for the join
//   exec_requested  per-core launch pulse
//   requested_pc    per-core start PC, core i at [i*PC_W +: PC_W]
//   sub_ended       per-core ended flag coming back from the sub cores
//   busy, n_busy    per-core busy flags and their population count
//
// Core FSM
//   state      | meaning
//   C_IDLE     | free, selectable by a fork
//   C_LAUNCH   | exec_requested pulse cycle, sub_ended ignored
//   C_WAIT_CLR | waiting for a stale ended flag from the last run to drop
//   C_RUN      | running, returns to C_IDLE when sub_ended rises
//
// Join FSM
//   state      | meaning
//   J_IDLE     | no join outstanding
//   J_WAIT     | forks blocked, waiting for busy == 0
// -----------------------------------------------------------------------------
module sub_dispatcher #(
   parameter int  N_SUB = 4,
   parameter int  PC_W  = 32,
   localparam int ID_W  = $clog2(N_SUB),
   localparam int CNT_W = $clog2(N_SUB + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fork_valid,
   input  logic [PC_W-1:0]         fork_pc,
   output logic                    fork_ready,
   output logic [ID_W-1:0]         fork_id,
   input  logic                    join_req,
   output logic                    join_done,
   output logic [N_SUB-1:0]        exec_requested,
   output logic [N_SUB*PC_W-1:0]   requested_pc,
   input  logic [N_SUB-1:0]        sub_ended,
   output logic [N_SUB-1:0]        busy,
   output logic [CNT_W-1:0]        n_busy
);

   localparam int SW = ID_W + 1;

   typedef enum logic [1:0] {C_IDLE, C_LAUNCH, C_WAIT_CLR, C_RUN} core_state_e;
   typedef enum logic {J_IDLE, J_WAIT} join_state_e;

   core_state_e               core_q [N_SUB];
   core_state_e               core_d [N_SUB];
   join_state_e               join_q, join_d;
   logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
   logic [N_SUB-1:0]          exec_q, exec_d;
   logic [N_SUB*PC_W-1:0]     pc_q, pc_d;
   logic                      join_done_q, join_done_d;

   logic [N_SUB-1:0]          idle;
   logic                      any_idle;
   logic [ID_W-1:0]           pick;
   logic                      accept;

   always_comb begin
      for (int i = 0; i < N_SUB; i++) begin
         idle[i] = (core_q[i] == C_IDLE);
         busy[i] = !idle[i];
      end
   end

   // Walk offsets from the far end down so the idle core closest to rr_ptr
   // is the one left in pick.
   always_comb begin : pick_core
      logic [SW-1:0] idx;
      pick     = rr_ptr_q;
      any_idle = 1'b0;
      idx      = '0;
      for (int off = N_SUB - 1; off >= 0; off--) begin
         idx = {1'b0, rr_ptr_q} + SW'(off);
         if (idx >= SW'(N_SUB)) begin
            idx = idx - SW'(N_SUB);
         end
         if (idle[idx[ID_W-1:0]]) begin
            pick     = idx[ID_W-1:0];
            any_idle = 1'b1;
         end
      end
   end

   assign fork_ready = any_idle && (join_q == J_IDLE) && !join_req;
   assign accept     = fork_valid && fork_ready;
   assign fork_id    = pick;

   always_comb begin
      pc_d   = pc_q;
      exec_d = '0;
      for (int i = 0; i < N_SUB; i++) begin
         core_d[i] = core_q[i];
         case (core_q[i])
            C_IDLE: begin
               if (accept && (pick == ID_W'(i))) begin
                  core_d[i]              = C_LAUNCH;
                  exec_d[i]              = 1'b1;
                  pc_d[i*PC_W +: PC_W]   = fork_pc;
               end
            end
            C_LAUNCH:   core_d[i] = C_WAIT_CLR;
            C_WAIT_CLR: if (!sub_ended[i]) core_d[i] = C_RUN;
            C_RUN:      if (sub_ended[i])  core_d[i] = C_IDLE;
            default:    core_d[i] = C_IDLE;
         endcase
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (pick == ID_W'(N_SUB - 1)) ? '0 : pick + ID_W'(1);
      end
   end

   always_comb begin
      join_d      = join_q;
      join_done_d = 1'b0;
      case (join_q)
         J_IDLE: if (join_req) join_d = J_WAIT;
         J_WAIT: begin
            if (busy == '0) begin
               join_done_d = 1'b1;
               join_d      = J_IDLE;
            end
         end
         default: join_d = J_IDLE;
      endcase
   end

   always_comb begin
      n_busy = '0;
      for (int i = 0; i < N_SUB; i++) begin
         n_busy = n_busy + CNT_W'(busy[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_SUB; i++) begin
            core_q[i] <= C_IDLE;
         end
         join_q      <= J_IDLE;
         rr_ptr_q    <= '0;
         exec_q      <= '0;
         pc_q        <= '0;
         join_done_q <= 1'b0;
      end else begin
         for (int i = 0; i < N_SUB; i++) begin
            core_q[i] <= core_d[i];
         end
         join_q      <= join_d;
         rr_ptr_q    <= rr_ptr_d;
         exec_q      <= exec_d;
         pc_q        <= pc_d;
         join_done_q <= join_done_d;
      end
   end

   assign exec_requested = exec_q;
   assign requested_pc   = pc_q;
   assign join_done      = join_done_q;

endmodule

// File: tb/tb_sub_dispatcher.sv
module tb_sub_dispatcher;

   localparam int N     = 4;
   localparam int PW    = 32;
   localparam int ID_W  = 2;
   localparam int CNT_W = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              fork_valid;
   logic [PW-1:0]     fork_pc;
   logic              fork_ready;
   logic [ID_W-1:0]   fork_id;
   logic              join_req;
   logic              join_done;
   logic [N-1:0]      exec_requested;
   logic [N*PW-1:0]   requested_pc;
   logic [N-1:0]      sub_ended;
   logic [N-1:0]      busy;
   logic [CNT_W-1:0]  n_busy;

   int checks = 0;
   int errors = 0;

   sub_dispatcher #(.N_SUB(N), .PC_W(PW)) dut (
      .clk            (clk),
      .rst            (rst),
      .fork_valid     (fork_valid),
      .fork_pc        (fork_pc),
      .fork_ready     (fork_ready),
      .fork_id        (fork_id),
      .join_req       (join_req),
      .join_done      (join_done),
      .exec_requested (exec_requested),
      .requested_pc   (requested_pc),
      .sub_ended      (sub_ended),
      .busy           (busy),
      .n_busy         (n_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic          fv;
      logic [31:0]   pc;
      logic          jr;
      logic [3:0]    se;
      logic          rdy;
      logic [1:0]    id;
      logic [3:0]    ex;
      logic [3:0]    bz;
      logic [2:0]    nb;
      logic          jd;
      logic [127:0]  rpc;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic fv, input logic [31:0] pc, input logic jr, input logic [3:0] se);
      fork_valid = fv;
      fork_pc    = pc;
      join_req   = jr;
      sub_ended  = se;
   endtask

   function automatic logic [127:0] pcs(input logic [31:0] p3, input logic [31:0] p2,
                                        input logic [31:0] p1, input logic [31:0] p0);
      return {p3, p2, p1, p0};
   endfunction

   initial begin
      // Each row: inputs for one cycle and the outputs seen in that cycle
      // before the next rising edge. Rows 0-4 are four back-to-back forks,
      // rows 5-7 a core finishing while a fork waits with every core busy.
      vecs[0] = '{1'b1, 32'h100, 1'b0, 4'b0000, 1'b1, 2'd0, 4'b0000, 4'b0000, 3'd0, 1'b0, 128'h0};
      vecs[1] = '{1'b1, 32'h200, 1'b0, 4'b0000, 1'b1, 2'd1, 4'b0001, 4'b0001, 3'd1, 1'b0,
                  pcs(32'h0, 32'h0, 32'h0, 32'h100)};
      vecs[2] = '{1'b1, 32'h300, 1'b0, 4'b0000, 1'b1, 2'd2, 4'b0010, 4'b0011, 3'd2, 1'b0,
                  pcs(32'h0, 32'h0, 32'h200, 32'h100)};
      vecs[3] = '{1'b1, 32'h400, 1'b0, 4'b0000, 1'b1, 2'd3, 4'b0100, 4'b0111, 3'd3, 1'b0,
                  pcs(32'h0, 32'h300, 32'h200, 32'h100)};
      vecs[4] = '{1'b0, 32'h0,   1'b0, 4'b0000, 1'b0, 2'd0, 4'b1000, 4'b1111, 3'd4, 1'b0,
                  pcs(32'h400, 32'h300, 32'h200, 32'h100)};
      vecs[5] = '{1'b1, 32'h500, 1'b0, 4'b0100, 1'b0, 2'd0, 4'b0000, 4'b1111, 3'd4, 1'b0,
                  pcs(32'h400, 32'h300, 32'h200, 32'h100)};
      vecs[6] = '{1'b1, 32'h500, 1'b0, 4'b0000, 1'b1, 2'd2, 4'b0000, 4'b1011, 3'd3, 1'b0,
                  pcs(32'h400, 32'h300, 32'h200, 32'h100)};
      vecs[7] = '{1'b0, 32'h0,   1'b0, 4'b0000, 1'b0, 2'd0, 4'b0100, 4'b1111, 3'd4, 1'b0,
                  pcs(32'h400, 32'h500, 32'h200, 32'h100)};

      rst = 1'b1;
      drv(1'b0, 32'h0, 1'b0, 4'b0000);
      #2;
      chk("rst_busy",   128'(busy), 128'(4'b0000));
      chk("rst_nbusy",  128'(n_busy), 128'(3'd0));
      chk("rst_exec",   128'(exec_requested), 128'(4'b0000));
      chk("rst_pc",     128'(requested_pc), 128'h0);
      chk("rst_jdone",  128'(join_done), 128'(1'b0));
      chk("rst_ready",  128'(fork_ready), 128'(1'b1));
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int v = 0; v < 8; v++) begin
         drv(vecs[v].fv, vecs[v].pc, vecs[v].jr, vecs[v].se);
         #1;
         chk($sformatf("v%0d_ready", v), 128'(fork_ready), 128'(vecs[v].rdy));
         if (vecs[v].rdy) chk($sformatf("v%0d_id", v), 128'(fork_id), 128'(vecs[v].id));
         chk($sformatf("v%0d_exec", v),  128'(exec_requested), 128'(vecs[v].ex));
         chk($sformatf("v%0d_busy", v),  128'(busy), 128'(vecs[v].bz));
         chk($sformatf("v%0d_nbusy", v), 128'(n_busy), 128'(vecs[v].nb));
         chk($sformatf("v%0d_jdone", v), 128'(join_done), 128'(vecs[v].jd));
         chk($sformatf("v%0d_pc", v),    128'(requested_pc), vecs[v].rpc);
         cyc();
      end

      // Reset mid-run with cores 0 and 2 running.
      drv(1'b0, 32'h0, 1'b0, 4'b0000);
      rst = 1'b1;
      #1;
      chk("clr_busy", 128'(busy), 128'(4'b0000));
      @(posedge clk);
      #1;
      rst = 1'b0;
      drv(1'b1, 32'h10, 1'b0, 4'b0000); #1; chk("t1_id0", 128'(fork_id), 128'(2'd0)); cyc();
      drv(1'b1, 32'h20, 1'b0, 4'b0000); #1; chk("t1_id1", 128'(fork_id), 128'(2'd1)); cyc();
      drv(1'b1, 32'h30, 1'b0, 4'b0000); #1; chk("t1_id2", 128'(fork_id), 128'(2'd2)); cyc();
      drv(1'b0, 32'h0, 1'b0, 4'b0000);
      cyc();
      cyc();
      drv(1'b0, 32'h0, 1'b0, 4'b0010);
      cyc();
      drv(1'b0, 32'h0, 1'b0, 4'b0000);
      #1;
      chk("t1_busy_pre", 128'(busy), 128'(4'b0101));
      chk("t1_pc_pre",   128'(requested_pc), pcs(32'h0, 32'h30, 32'h20, 32'h10));
      #2;
      rst = 1'b1;
      #1;
      chk("t1_busy",  128'(busy), 128'(4'b0000));
      chk("t1_nbusy", 128'(n_busy), 128'(3'd0));
      chk("t1_exec",  128'(exec_requested), 128'(4'b0000));
      chk("t1_pc",    128'(requested_pc), 128'h0);
      chk("t1_ready", 128'(fork_ready), 128'(1'b1));
      chk("t1_jdone", 128'(join_done), 128'(1'b0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      drv(1'b1, 32'h40, 1'b0, 4'b0000);
      #1;
      chk("t1_post_ready", 128'(fork_ready), 128'(1'b1));
      chk("t1_post_id",    128'(fork_id), 128'(2'd0));
      cyc();
      chk("t1_post_exec",  128'(exec_requested), 128'(4'b0001));
      chk("t1_post_pc",    128'(requested_pc), pcs(32'h0, 32'h0, 32'h0, 32'h40));

      // Stale ended flag on core 1 held through LAUNCH and WAIT_CLR.
      drv(1'b1, 32'h55, 1'b0, 4'b0010);
      #1;
      chk("t4_id", 128'(fork_id), 128'(2'd1));
      cyc();
      drv(1'b0, 32'h0, 1'b0, 4'b0010);
      #1;
      chk("t4_exec", 128'(exec_requested), 128'(4'b0010));
      chk("t4_busy_launch", 128'(busy[1]), 128'(1'b1));
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk($sformatf("t4_busy_stale%0d", k), 128'(busy[1]), 128'(1'b1));
         chk($sformatf("t4_exec_stale%0d", k), 128'(exec_requested), 128'(4'b0000));
      end
      drv(1'b0, 32'h0, 1'b0, 4'b0000);
      cyc();
      chk("t4_busy_run", 128'(busy[1]), 128'(1'b1));
      drv(1'b0, 32'h0, 1'b0, 4'b0010);
      cyc();
      chk("t4_busy_end", 128'(busy[1]), 128'(1'b0));

      // Join with cores 1 and 3 busy; core 3 ends first, then core 1.
      drv(1'b0, 32'h0, 1'b0, 4'b0001);
      cyc();
      drv(1'b0, 32'h0, 1'b0, 4'b0000);
      #1;
      chk("t5_all_idle", 128'(busy), 128'(4'b0000));
      drv(1'b1, 32'hA2, 1'b0, 4'b0000); #1; chk("t5_id2", 128'(fork_id), 128'(2'd2)); cyc();
      drv(1'b1, 32'hA3, 1'b0, 4'b0000); #1; chk("t5_id3", 128'(fork_id), 128'(2'd3)); cyc();
      drv(1'b1, 32'hA0, 1'b0, 4'b0000); #1; chk("t5_id0", 128'(fork_id), 128'(2'd0)); cyc();
      drv(1'b1, 32'hA1, 1'b0, 4'b0000); #1; chk("t5_id1", 128'(fork_id), 128'(2'd1)); cyc();
      drv(1'b0, 32'h0, 1'b0, 4'b0000);
      #1;
      chk("t5_full_ready", 128'(fork_ready), 128'(1'b0));
      chk("t5_full_busy",  128'(busy), 128'(4'b1111));
      cyc();
      cyc();
      drv(1'b0, 32'h0, 1'b0, 4'b0101);
      cyc();
      drv(1'b0, 32'h0, 1'b0, 4'b0000);
      #1;
      chk("t5_busy13", 128'(busy), 128'(4'b1010));
      chk("t5_pc",     128'(requested_pc), pcs(32'hA3, 32'hA2, 32'hA1, 32'hA0));
      drv(1'b1, 32'hBB, 1'b1, 4'b0000);
      #1;
      chk("t5_ready_req", 128'(fork_ready), 128'(1'b0));
      cyc();
      chk("t5_ready_wait", 128'(fork_ready), 128'(1'b0));
      chk("t5_exec_wait",  128'(exec_requested), 128'(4'b0000));
      chk("t5_jd_wait",    128'(join_done), 128'(1'b0));
      drv(1'b1, 32'hBB, 1'b1, 4'b1000);
      cyc();
      drv(1'b1, 32'hBB, 1'b1, 4'b0000);
      #1;
      chk("t5_busy1",      128'(busy), 128'(4'b0010));
      chk("t5_ready_idle", 128'(fork_ready), 128'(1'b0));
      chk("t5_jd_c3",      128'(join_done), 128'(1'b0));
      cyc();
      chk("t5_jd_hold",    128'(join_done), 128'(1'b0));
      chk("t5_exec_hold",  128'(exec_requested), 128'(4'b0000));
      drv(1'b1, 32'hBB, 1'b1, 4'b0010);
      cyc();
      drv(1'b1, 32'hBB, 1'b1, 4'b0000);
      #1;
      chk("t5_busy0",   128'(busy), 128'(4'b0000));
      chk("t5_jd_last", 128'(join_done), 128'(1'b0));
      cyc();
      chk("t5_jd_pulse", 128'(join_done), 128'(1'b1));
      chk("t5_exec_jd",  128'(exec_requested), 128'(4'b0000));
      drv(1'b0, 32'h0, 1'b0, 4'b0000);
      cyc();
      chk("t5_jd_fall",  128'(join_done), 128'(1'b0));
      chk("t5_ready_after", 128'(fork_ready), 128'(1'b1));

      // Join with every core idle: J_WAIT is entered on the first edge and
      // join_done follows one cycle later.
      drv(1'b0, 32'h0, 1'b1, 4'b0000);
      #1;
      chk("t6_jd_req", 128'(join_done), 128'(1'b0));
      cyc();
      chk("t6_jd_wait", 128'(join_done), 128'(1'b0));
      chk("t6_exec_wait", 128'(exec_requested), 128'(4'b0000));
      cyc();
      chk("t6_jd_pulse", 128'(join_done), 128'(1'b1));
      chk("t6_exec_pulse", 128'(exec_requested), 128'(4'b0000));
      drv(1'b0, 32'h0, 1'b0, 4'b0000);
      cyc();
      chk("t6_jd_fall", 128'(join_done), 128'(1'b0));
      chk("t6_exec_end", 128'(exec_requested), 128'(4'b0000));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
